// File: rtl/mem_if_pkg.sv
// Shared types and default sizing for the memory request initiator and its timeout timer.
package mem_if_pkg;

   localparam int unsigned MEM_ADDR_W         = 4;
   localparam int unsigned MEM_DATA_W         = 32;
   localparam int unsigned MEM_TIMEOUT_CYCLES = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } mem_req_state_e;

endpackage

// File: rtl/mem_req_timer.sv
// REQ-phase watchdog: counts enabled cycles since the last clear and flags the final allowed cycle.
module mem_req_timer
   import mem_if_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
)(
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds completed REQ cycles, so this marks the TIMEOUT_CYCLES-th one.
   assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_req_initiator.sv
// Single-outstanding memory request initiator; optional REQ timeout under MEM_REQ_TIMEOUT_EN.
// state | meaning:  IDLE | ready for a command ;  REQ | req_o high, waiting ready ;  GAP | rsp pulse, req_o low
module mem_req_initiator
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDR_W         = MEM_ADDR_W,
   parameter int unsigned DATA_W         = MEM_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_rnw_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              req_o,
   output logic              req_rnw_o,
   output logic [ADDR_W-1:0] req_addr_o,
   output logic [DATA_W-1:0] req_wdata_o,
   input  logic              req_ready_i,
   input  logic [DATA_W-1:0] req_rdata_i
);

   if ((ADDR_W < 1) || (DATA_W < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
      $error("mem_req_initiator: ADDR_W, DATA_W and TIMEOUT_CYCLES must all be at least 1");
   end

   mem_req_state_e    state_q;
   logic              req_q;
   logic              req_rnw_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic [DATA_W-1:0] req_wdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              cmd_fire;
   logic              timeout;

   assign cmd_ready_o = (state_q == IDLE) && !reset;
   assign cmd_fire    = cmd_valid_i && cmd_ready_o;

`ifdef MEM_REQ_TIMEOUT_EN
   logic rsp_err_q;

   mem_req_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (cmd_fire),
      .en_i      (state_q == REQ),
      .expired_o (timeout)
   );

   assign rsp_err_o = rsp_err_q;
`else
   assign timeout   = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         req_rnw_q   <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cmd_fire) begin
                  state_q     <= REQ;
                  req_q       <= 1'b1;
                  req_rnw_q   <= cmd_rnw_i;
                  req_addr_q  <= cmd_addr_i;
                  req_wdata_q <= cmd_wdata_i;
               end
            end
            REQ: begin
               // Ready is checked first so a completion on the timeout edge still succeeds.
               if (req_ready_i) begin
                  state_q     <= GAP;
                  req_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= req_rnw_q ? req_rdata_i : '0;
`ifdef MEM_REQ_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
`endif
               end else if (timeout) begin
                  state_q     <= GAP;
                  req_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
                  rsp_err_q   <= 1'b1;
`endif
               end
            end
            GAP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign req_o       = req_q;
   assign req_rnw_o   = req_rnw_q;
   assign req_addr_o  = req_addr_q;
   assign req_wdata_o = req_wdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed and randomized bench for mem_req_initiator with a behavioural memory responder.
module tb_mem_req_initiator;

   localparam int ADDR_W         = 4;
   localparam int DATA_W         = 32;
   localparam int TIMEOUT_CYCLES = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid_i = 1'b0;
   logic              cmd_ready_o;
   logic              cmd_rnw_i = 1'b0;
   logic [ADDR_W-1:0] cmd_addr_i = '0;
   logic [DATA_W-1:0] cmd_wdata_i = '0;
   logic              rsp_valid_o;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_err_o;
   logic              req_o;
   logic              req_rnw_o;
   logic [ADDR_W-1:0] req_addr_o;
   logic [DATA_W-1:0] req_wdata_o;
   logic              req_ready_i = 1'b0;
   logic [DATA_W-1:0] req_rdata_i = '0;

   logic [DATA_W-1:0] mem_model [16];
   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_req_initiator #(
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_rnw_i   (cmd_rnw_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .req_o       (req_o),
      .req_rnw_o   (req_rnw_o),
      .req_addr_o  (req_addr_o),
      .req_wdata_o (req_wdata_o),
      .req_ready_i (req_ready_i),
      .req_rdata_i (req_rdata_i)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One full transaction: memory raises ready in REQ cycle wait_n+1.
   task automatic do_txn(input logic rnw, input logic [3:0] addr, input logic [31:0] wdata,
                         input int wait_n);
      logic [31:0] exp_rd;
      int k;
      cmd_valid_i = 1'b1;
      cmd_rnw_i   = rnw;
      cmd_addr_i  = addr;
      cmd_wdata_i = wdata;
      k = 0;
      while (!cmd_ready_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      cmd_rnw_i   = ~rnw;
      cmd_addr_i  = ~addr;
      cmd_wdata_i = ~wdata;
      exp_rd = rnw ? mem_model[addr] : 32'h0;
      for (int i = 0; i <= wait_n; i++) begin
         req_ready_i = (i == wait_n);
         req_rdata_i = rnw ? mem_model[addr] : $urandom;
         @(negedge clk);
         chk("req_high",       {31'd0, req_o},       32'd1);
         chk("req_addr",       {28'd0, req_addr_o},  {28'd0, addr});
         chk("req_rnw",        {31'd0, req_rnw_o},   {31'd0, rnw});
         chk("req_wdata",      req_wdata_o,          wdata);
         chk("rsp_idle_inreq", {31'd0, rsp_valid_o}, 32'd0);
         @(posedge clk); #1;
      end
      req_ready_i = 1'b0;
      req_rdata_i = $urandom;
      @(negedge clk);
      chk("gap_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("gap_req_low",   {31'd0, req_o},       32'd0);
      chk("gap_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
      chk("gap_rdata",     rsp_rdata_o,          exp_rd);
      chk("gap_err",       {31'd0, rsp_err_o},   32'd0);
      if (!rnw) mem_model[addr] = wdata;
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_rsp_low",   {31'd0, rsp_valid_o}, 32'd0);
      chk("idle_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      chk("idle_rdata_hold", rsp_rdata_o,         exp_rd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_req;
      int pulses;
      int rises;
      int last_rise;
      int acc;
      int viol;
      logic prev_req;
      logic accept;

      for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
      chk("rst_req",       {31'd0, req_o},       32'd0);
      chk("rst_rnw",       {31'd0, req_rnw_o},   32'd0);
      chk("rst_addr",      {28'd0, req_addr_o},  32'd0);
      chk("rst_wdata",     req_wdata_o,          32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      chk("rst_rdata",     rsp_rdata_o,          32'd0);
      chk("rst_err",       {31'd0, rsp_err_o},   32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rel_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);

      // Write then read with zero-wait memory
      do_txn(1'b0, 4'h3, 32'hDEADBEEF, 0);
      do_txn(1'b1, 4'h3, 32'h0, 0);
      chk("rd_deadbeef", rsp_rdata_o, 32'hDEADBEEF);

      // Delayed ready: 7 wait cycles, 8 REQ cycles
      do_txn(1'b0, 4'h9, 32'hA5A5_0F0F, 7);
      do_txn(1'b1, 4'h9, 32'h0, 7);
      chk("rd_delayed", rsp_rdata_o, 32'hA5A5_0F0F);

      // Back-to-back writes with cmd_valid held high
      @(posedge clk); #1;
      cmd_valid_i = 1'b1;
      cmd_rnw_i   = 1'b0;
      cmd_addr_i  = 4'h0;
      cmd_wdata_i = 32'hB0B0_0000;
      req_ready_i = 1'b1;
      pulses = 0; rises = 0; acc = 0; viol = 0; last_rise = -1; prev_req = 1'b0;
      for (int c = 0; c < 30 && pulses < 4; c++) begin
         @(negedge clk);
         if (rsp_valid_o) pulses++;
         if (req_o && !prev_req) begin
            chk("b2b_addr", {28'd0, req_addr_o}, rises);
            if (last_rise >= 0) chk("b2b_period", c - last_rise, 32'd3);
            last_rise = c;
            rises++;
         end
         if (req_o && prev_req) viol++;
         prev_req = req_o;
         accept = cmd_valid_i && cmd_ready_o;
         @(posedge clk); #1;
         if (accept) begin
            mem_model[acc] = cmd_wdata_i;
            acc++;
            if (acc == 4) cmd_valid_i = 1'b0;
            else begin
               cmd_addr_i  = 4'(acc);
               cmd_wdata_i = 32'hB0B0_0000 + acc;
            end
         end
      end
      req_ready_i = 1'b0;
      cmd_valid_i = 1'b0;
      chk("b2b_pulses", pulses, 32'd4);
      chk("b2b_reqs",   rises,  32'd4);
      chk("b2b_no_gap", viol,   32'd0);
      do_txn(1'b1, 4'h2, 32'h0, 1);
      chk("b2b_readback", rsp_rdata_o, 32'hB0B0_0002);

      // Reset asserted in the third REQ cycle
      @(posedge clk); #1;
      cmd_valid_i = 1'b1; cmd_rnw_i = 1'b0; cmd_addr_i = 4'h5; cmd_wdata_i = 32'h1234_5678;
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_req_before", {31'd0, req_o}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_req_dropped", {31'd0, req_o},       32'd0);
      chk("mid_no_rsp",      {31'd0, rsp_valid_o}, 32'd0);
      chk("mid_cmd_ready",   {31'd0, cmd_ready_o}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      viol = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid_o || req_o) viol++;
         if (c == 0) chk("mid_rel_ready", {31'd0, cmd_ready_o}, 32'd1);
         @(posedge clk); #1;
      end
      chk("mid_quiet", viol, 32'd0);

      // Timeout behaviour with ready held low
      cmd_valid_i = 1'b1; cmd_rnw_i = 1'b0; cmd_addr_i = 4'h7; cmd_wdata_i = 32'hCAFE_F00D;
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      req_ready_i = 1'b0;
      n_req = 0;
`ifdef MEM_REQ_TIMEOUT_EN
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (!req_o) break;
         n_req++;
         @(posedge clk); #1;
      end
      chk("to_req_cycles", n_req, 32'd32);
      chk("to_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("to_err",       {31'd0, rsp_err_o},   32'd1);
      chk("to_rdata",     rsp_rdata_o,          32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_err_hold",  {31'd0, rsp_err_o},   32'd1);
      chk("to_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
`else
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (req_o && !rsp_valid_o) n_req++;
         @(posedge clk); #1;
      end
      chk("no_to_req_held", n_req, 32'd120);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("no_to_rel_ready", {31'd0, cmd_ready_o}, 32'd1);
`endif
      // Ready on the last allowed REQ cycle must complete without error
      do_txn(1'b0, 4'h7, 32'h7777_0007, TIMEOUT_CYCLES - 1);
      do_txn(1'b1, 4'h7, 32'h0, 0);
      chk("edge_readback", rsp_rdata_o, 32'h7777_0007);

      // Random traffic against the responder model
      for (int t = 0; t < 200; t++) begin
         logic        r_rnw;
         logic [3:0]  r_addr;
         logic [31:0] r_wdata;
         r_rnw   = 1'($urandom_range(0, 1));
         r_addr  = 4'($urandom_range(0, 15));
         r_wdata = $urandom;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         do_txn(r_rnw, r_addr, r_wdata, int'($urandom_range(0, 5)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
